sram_port_arbiter: RTL
======================

# sram_port_arbiter

Shares the single external SRAM port (18-bit word address, 32-bit data) between up to four engines: memory blanking, frame capture writer, image-processing read/write, and host access. Each requester keeps the pause-style handshake the engines already use, so existing engines attach without change. The block round-robin grants the port, registers the selected command onto the SRAM pins, and routes read data back to the issuing requester with a valid strobe.

## Interface
- NUM_REQ, 4, number of requesters (2..4)
- READ_LATENCY, 2, cycles from registered SRAM address to valid sram_data_read (1..4)
- MAX_BURST, 64, consecutive granted cycles before forced rotation (used only with SRAM_ARB_BURST_LIMIT_EN)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  requester i wants the port
- req_wren  in  NUM_REQ  per-requester write enable
- req_address  in  NUM_REQ*18  per-requester address, requester i at [18*i +: 18]
- req_data_write  in  NUM_REQ*32  per-requester write data
- pause  out  NUM_REQ  1 = not granted; requester must hold its command
- rd_data  out  32  read data, shared by all requesters
- rd_valid  out  NUM_REQ  one-cycle strobe: rd_data belongs to requester i
- sram_wren  out  1  registered write enable to SRAM
- sram_address  out  18  registered address
- sram_data_write  out  32  registered write data
- sram_data_read  in  32  SRAM read data

## Operation
- States: IDLE (no owner), OWN (one owner, index owner).
- IDLE: at posedge, if any req, owner <= first requester set, searching from last_owner+1 modulo NUM_REQ. Go to OWN. pause[owner] drops in the following cycle.
- OWN: each cycle with req[owner]=1 and pause[owner]=0 is a command cycle. sram_wren/address/data_write <= that requester's inputs. If wren=0, a read tag (owner index) enters the tag pipe.
- OWN, req[owner]=0: no command is issued (sram_wren <= 0). The owner is released in the same edge. Next grant follows the IDLE rule from owner+1, so the handoff takes 0 idle cycles if another req is pending.
- Non-command cycles drive sram_wren=0 and hold address/data.
- Read return: READ_LATENCY cycles after the address is on the pins, rd_data <= sram_data_read and rd_valid[tag] pulses. Delivery is independent of the current grant.
- Simultaneous requests are resolved only by round-robin order. Requesters that are not granted see pause=1 and are otherwise ignored.

## Timing
- Reset values: pause = all 1, rd_valid = 0, rd_data = 0, sram_wren = 0, sram_address = 0, sram_data_write = 0, state IDLE, last_owner = NUM_REQ-1, tag pipe empty.
- Grant latency: req rises at cycle n → pause=0 at n+1 → first command on the pins at n+2.
- Write: the command at the requester's cycle k appears on the pins at k+1.
- Read: rd_valid at k+1+READ_LATENCY.
- Throughput: one command per cycle under sustained ownership.
- Reset mid-operation: the grant is revoked, sram_wren=0 on the next edge, and in-flight read tags are discarded (no rd_valid).

## Configuration
- SRAM_ARB_BURST_LIMIT_EN defined:
  - A burst counter counts command cycles of the current owner.
  - After MAX_BURST commands, if any other req is pending, the owner is forced off: pause[owner]=1 next cycle and the grant rotates.
  - If no other requester is pending, the counter restarts and ownership continues.
- Undefined: ownership lasts until req[owner] drops, and the counter is not synthesized.

## Structure
- Package sram_arb_pkg holds SRAM_ADDR_W=18, SRAM_DATA_W=32, MAX_REQ=4, and the state encoding constants.
- Sub-module sram_arb_tag_pipe: a READ_LATENCY+1-deep shift register of {valid, index}, with synchronous clear on reset.

## Test plan
- Single requester 0 writes 0x00000–0x00003 with data 0x11223300+addr → pins show each write 1 cycle after the command cycle; pause[0]=0 from cycle n+1.
- Requesters 1 and 2 raise req on the same cycle after reset → 1 granted first; on its req drop, 2 granted with no idle cycle.
- Requester 3 reads address 0x3FFFF with the SRAM model returning 0xDEADBEEF → rd_valid[3] pulses exactly READ_LATENCY+1 cycles after the command, while requester 0 holds the grant.
- With SRAM_ARB_BURST_LIMIT_EN and MAX_BURST=64: requester 0 streams and requester 1 waits → after 64 commands pause[0]=1 and requester 1 is granted.
- Same MAX_BURST=64 setup with requester 1 idle → requester 0 keeps the grant past 64 commands.
- Reset asserted mid-burst with 2 reads in flight → next edge sram_wren=0 and pause all 1; no rd_valid appears afterward.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM encoding, read-tag layout and the round-robin picker
// used by the SRAM port arbiter.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 32;
  localparam int MAX_REQ     = 4;
  localparam int IDX_W       = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  // First set bit of vec at or after start, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] vec,
    input logic [IDX_W-1:0]   start,
    input int                 n
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    int               j;
    pick = start;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(start) + k;
        if (j >= n) j = j - n;
        cand = IDX_W'(j);
        if (vec[cand]) pick = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: packed per-requester
// commands in, pause / shared read data / per-requester read strobe out.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                           req;
  logic [NUM_REQ-1:0]                           req_wren;
  logic [NUM_REQ*sram_arb_pkg::SRAM_ADDR_W-1:0] req_address;
  logic [NUM_REQ*sram_arb_pkg::SRAM_DATA_W-1:0] req_data_write;
  logic [NUM_REQ-1:0]                           pause;
  logic [sram_arb_pkg::SRAM_DATA_W-1:0]         rd_data;
  logic [NUM_REQ-1:0]                           rd_valid;

  modport master (
    output req, req_wren, req_address, req_data_write,
    input  pause, rd_data, rd_valid
  );

  modport slave (
    input  req, req_wren, req_address, req_data_write,
    output pause, rd_data, rd_valid
  );

endinterface

// File: rtl/sram_arb_tag_pipe.sv
// Read-tag delay line: READ_LATENCY+1 stages of {valid, requester index};
// the last stage marks the cycle a read's data is presented to its requester.
module sram_arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic             capture,
  output rd_tag_t          head
);

  rd_tag_t stage [READ_LATENCY+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j <= READ_LATENCY; j++) stage[j] <= '0;
    end else begin
      stage[0] <= '{valid: push, idx: push_idx};
      for (int j = 1; j <= READ_LATENCY; j++) stage[j] <= stage[j-1];
    end
  end

  // SRAM data is sampled on the edge that moves a tag into the last stage.
  assign capture = stage[READ_LATENCY-1].valid;
  assign head    = stage[READ_LATENCY];

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin owner of the shared SRAM port with registered pins and tagged
// read return. Optional burst limit: define SRAM_ARB_BURST_LIMIT_EN.
//
// state   | meaning
// ST_IDLE | no owner; owner holds the last owner for round-robin order
// ST_OWN  | requester "owner" holds the port and issues commands
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_port_arbiter_if.slave     bus,
  output logic                   sram_wren,
  output logic [SRAM_ADDR_W-1:0] sram_address,
  output logic [SRAM_DATA_W-1:0] sram_data_write,
  input  logic [SRAM_DATA_W-1:0] sram_data_read
);

  arb_state_t             state;
  logic [IDX_W-1:0]       owner;
  logic [NUM_REQ-1:0]     pause_q;
  logic [SRAM_DATA_W-1:0] rd_data_q;

  logic [MAX_REQ-1:0]     req_pad;
  logic [MAX_REQ-1:0]     wren_pad;
  logic [MAX_REQ-1:0]     pause_pad;
  logic [MAX_REQ-1:0]     cand;
  logic [MAX_REQ-1:0]     rd_valid_pad;
  logic [IDX_W-1:0]       start_idx;
  logic [IDX_W-1:0]       nxt;
  logic [NUM_REQ-1:0]     grant_pause;
  logic [SRAM_ADDR_W-1:0] sel_address;
  logic [SRAM_DATA_W-1:0] sel_data;
  logic                   sel_wren;
  logic                   owner_req;
  logic                   any_cand;
  logic                   cmd;
  logic                   burst_term;
  logic                   grant;
  logic                   release_idle;
  logic                   capture;
  rd_tag_t                head;

  always_comb begin
    req_pad                 = '0;
    req_pad[NUM_REQ-1:0]    = bus.req;
    wren_pad                = '0;
    wren_pad[NUM_REQ-1:0]   = bus.req_wren;
    pause_pad               = '1;
    pause_pad[NUM_REQ-1:0]  = pause_q;

    owner_req   = req_pad[owner];
    sel_wren    = wren_pad[owner];
    sel_address = bus.req_address[int'(owner)*SRAM_ADDR_W +: SRAM_ADDR_W];
    sel_data    = bus.req_data_write[int'(owner)*SRAM_DATA_W +: SRAM_DATA_W];
    cmd         = (state == ST_OWN) && owner_req && !pause_pad[owner];

    // While owning, the current owner is excluded so a forced rotation
    // cannot hand the port straight back to it.
    cand = req_pad;
    if (state == ST_OWN) cand[owner] = 1'b0;
    start_idx = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
    nxt       = rr_pick(cand, start_idx, NUM_REQ);
    any_cand  = |cand;

    grant_pause = '1;
    for (int i = 0; i < NUM_REQ; i++) grant_pause[i] = (IDX_W'(i) != nxt);

    grant = any_cand &&
            ((state == ST_IDLE) || ((state == ST_OWN) && (!owner_req || burst_term)));
    release_idle = (state == ST_OWN) && !owner_req && !any_cand;
  end

`ifdef SRAM_ARB_BURST_LIMIT_EN
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [BURST_W-1:0] burst_left;

  assign burst_term = cmd && (burst_left == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_left <= BURST_W'(MAX_BURST - 1);
    end else if (grant || burst_term) begin
      burst_left <= BURST_W'(MAX_BURST - 1);
    end else if (cmd) begin
      burst_left <= burst_left - 1'b1;
    end
  end
`else
  // Never asserts for a legal MAX_BURST: ownership ends only when req drops.
  assign burst_term = (MAX_BURST < 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      owner           <= IDX_W'(NUM_REQ - 1);
      pause_q         <= '1;
      sram_wren       <= 1'b0;
      sram_address    <= '0;
      sram_data_write <= '0;
    end else begin
      sram_wren <= cmd && sel_wren;
      if (cmd) begin
        sram_address    <= sel_address;
        sram_data_write <= sel_data;
      end
      if (grant) begin
        state   <= ST_OWN;
        owner   <= nxt;
        pause_q <= grant_pause;
      end else if (release_idle) begin
        state   <= ST_IDLE;
        pause_q <= '1;
      end
    end
  end

  sram_arb_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd && !sel_wren),
    .push_idx (owner),
    .capture  (capture),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (capture) begin
      rd_data_q <= sram_data_read;
    end
  end

  always_comb begin
    rd_valid_pad = '0;
    if (head.valid) rd_valid_pad[head.idx] = 1'b1;
  end

  assign bus.pause    = pause_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_pad[NUM_REQ-1:0];

endmodule
